// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment patterns
// ({g,f,e,d,c,b,a}), blink field encodings and digit count.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef enum logic [1:0] {
        FLD_SD  = 2'b00,
        FLD_MN  = 2'b01,
        FLD_HR  = 2'b10,
        FLD_ALL = 2'b11
    } fld_e;

endpackage

// File: rtl/seg_scan_if.sv
// Time word / display control in, multiplexed display pins out.
interface seg_scan_if;
    logic [23:0] tm;
    logic        blink_en;
    logic [1:0]  blink_sel;
    logic        colon_en;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    modport master (
        output tm, blink_en, blink_sel, colon_en,
        input  an, seg, dp, frame
    );

    modport slave (
        input  tm, blink_en, blink_sel, colon_en,
        output an, seg, dp, frame
    );
endinterface

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low seven-segment pattern; non-BCD values show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Six-digit common-anode display scanner with per-frame snapshot, field blink
// and decimal-point colon. All display outputs are registered on scan ticks.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          run;
    logic [23:0]   shadow;
    logic [FW-1:0] fcnt;
    logic          hidden;

    logic          tick;
    logic          enter0;
    logic          fcnt_tc;
    logic          hidden_nxt;
    logic [2:0]    idx_nxt;
    logic [23:0]   word;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic          blank;
    logic [5:0]    an_nxt;
    logic          dp_nxt;

    assign tick    = (presc == PW'(SCAN_DIV - 1));
    // Until the first tick after reset nothing is lit, so that tick enters
    // digit 0 rather than advancing to digit 1.
    assign enter0  = tick && (!run || idx == 3'(NUM_DIGITS - 1));
    assign idx_nxt = enter0 ? 3'd0 : idx + 3'd1;
    assign fcnt_tc = (fcnt == FW'(BLINK_DIV - 1));

    assign hidden_nxt = (enter0 && fcnt_tc) ? ~hidden : hidden;

    // Digit 0 reads tm directly since the shadow is loaded on the same edge.
    assign word = enter0 ? bus.tm : shadow;

    always_comb begin
        nib = word[3:0];
        case (idx_nxt)
            3'd1:    nib = word[7:4];
            3'd2:    nib = word[11:8];
            3'd3:    nib = word[15:12];
            3'd4:    nib = word[19:16];
            3'd5:    nib = word[23:20];
            default: nib = word[3:0];
        endcase
    end

    bcd_to_seg u_dec (
        .bcd (nib),
        .seg (seg_dec)
    );

    assign blank  = bus.blink_en && hidden_nxt &&
                    (fld_e'(bus.blink_sel) == FLD_ALL ||
                     fld_e'(bus.blink_sel) == fld_e'(idx_nxt[2:1]));
    assign an_nxt = ~(6'd1 << idx_nxt) | {6{blank}};
    assign dp_nxt = ~(bus.colon_en && (idx_nxt == 3'd2 || idx_nxt == 3'd4));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            idx       <= 3'd0;
            run       <= 1'b0;
            shadow    <= '0;
            fcnt      <= '0;
            hidden    <= 1'b0;
            bus.an    <= 6'b111111;
            bus.seg   <= 7'h7F;
            bus.dp    <= 1'b1;
            bus.frame <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            bus.frame <= enter0;
            if (tick) begin
                idx     <= idx_nxt;
                run     <= 1'b1;
                bus.an  <= an_nxt;
                bus.seg <= seg_dec;
                bus.dp  <= dp_nxt;
            end
            if (enter0) begin
                shadow <= bus.tm;
                fcnt   <= fcnt_tc ? '0 : fcnt + FW'(1);
                hidden <= hidden_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: per-digit expectations queued at drive time and
// checked when the scan tick presents that digit.
module tb_seg_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
        int         dg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          dg       = 0;
    int          fr       = -1;
    logic [23:0] snap     = '0;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " an"},    32'(bus.an),    32'h3F);
        chk({tag, " seg"},   32'(bus.seg),   32'h7F);
        chk({tag, " dp"},    32'(bus.dp),    32'h1);
        chk({tag, " frame"}, 32'(bus.frame), 32'h0);
    endtask

    // Frame fr is hidden once an odd number of BLINK_DIV-frame windows elapsed.
    task automatic push_digit();
        exp_t       e;
        logic [3:0] nib;
        logic       hid;
        logic       blank;
        if (dg == 0) begin
            fr++;
            snap = bus.tm;
        end
        nib   = snap[4*dg +: 4];
        hid   = (((fr + 1) / BLINK_DIV) % 2) == 1;
        blank = bus.blink_en && hid &&
                (bus.blink_sel == 2'b11 || int'(bus.blink_sel) == dg / 2);
        for (int i = 0; i < 6; i++)
            e.an[i] = (i != dg) || blank;
        e.seg   = ref_seg(nib);
        e.dp    = !(bus.colon_en && (dg == 2 || dg == 4));
        e.frame = (dg == 0);
        e.dg    = dg;
        sb.push_back(e);
        dg = (dg + 1) % 6;
    endtask

    task automatic run_digits(input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            push_digit();
            for (int c = 1; c <= SCAN_DIV; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (c < SCAN_DIV)
                    chk($sformatf("frame idle d%0d c%0d", sb[0].dg, c), 32'(bus.frame), 32'h0);
            end
            e = sb.pop_front();
            chk($sformatf("an d%0d f%0d", e.dg, fr),    32'(bus.an),    32'(e.an));
            chk($sformatf("seg d%0d f%0d", e.dg, fr),   32'(bus.seg),   32'(e.seg));
            chk($sformatf("dp d%0d f%0d", e.dg, fr),    32'(bus.dp),    32'(e.dp));
            chk($sformatf("frame d%0d f%0d", e.dg, fr), 32'(bus.frame), 32'(e.frame));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tm        = 24'h000000;
        bus.blink_en  = 1'b0;
        bus.blink_sel = 2'b00;
        bus.colon_en  = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // scan order and timing
        bus.tm = 24'h123456;
        run_digits(12);

        // change tm while digit 3 is lit; digits 4,5 keep the old snapshot
        run_digits(4);
        bus.tm = 24'h235959;
        run_digits(8);

        // invalid BCD nibble in digit 4
        bus.tm = 24'h1A0000;
        run_digits(6);

        // colon on, then off
        bus.tm       = 24'h095817;
        bus.colon_en = 1'b1;
        run_digits(6);
        bus.colon_en = 1'b0;
        run_digits(6);

        // blink minutes, then all, then seconds, then release
        bus.blink_en  = 1'b1;
        bus.blink_sel = 2'b01;
        run_digits(24);
        bus.blink_sel = 2'b11;
        run_digits(12);
        bus.blink_sel = 2'b00;
        bus.colon_en  = 1'b1;
        run_digits(12);
        bus.blink_en  = 1'b0;
        run_digits(6);
        bus.colon_en  = 1'b0;

        // reset while digit 4 is lit
        run_digits(5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("mid reset");
        rst = 1'b0;
        dg  = 0;
        fr  = -1;
        bus.tm = 24'h204508;
        run_digits(7);

        chk("scoreboard empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Downstream consumer of the 24-bit packed time word {hr,mn,sd} (8-bit BCD per field) produced by the time/alarm select stage.
- Drives a 6-digit common-anode seven-segment display by time-multiplexed digit scanning.
- Supports field blinking while a value is being set, and a colon drawn with decimal points.
- Sits between the select stage and the board pins. All outputs are registered.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit. Must be >= 2.
- BLINK_DIV, 250: full 6-digit frames per blink half-period. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tm  input  24  {hr[7:4],hr[3:0],mn[7:4],mn[3:0],sd[7:4],sd[3:0]} BCD
- blink_en  input  1  enable blinking of the selected field
- blink_sel  input  2  field to blink: 00 = sd, 01 = mn, 10 = hr, 11 = all digits
- colon_en  input  1  light the decimal points that separate hr:mn:sd
- an  output  6  digit enables, active-low; bit 0 = rightmost digit (sd ones), bit 5 = hr tens
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame  output  1  one-cycle pulse when digit 0 is entered

Behaviour:
- Reset: an=6'b111111, seg=7'h7F, dp=1, frame=0, prescaler=0, idx=0, shadow=0, blink phase=visible, frame counter=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. A tick occurs on the cycle where the count equals SCAN_DIV-1.
- On a tick, idx advances 0→1→…→5→0.
- Outputs for the new idx are registered on the tick edge, so they are visible the cycle after the tick.
- Shadow latch:
  - When idx wraps 5→0, tm is captured into a shadow register in the same edge.
  - All six digits of a frame come from one snapshot, so there is no tearing.
  - tm changes mid-frame are not shown until the next frame.
- frame pulses high for one cycle on the same edge as the shadow capture.
- Nibble decode:
  - 0-9 map to standard segment patterns.
  - Any nibble >9 shows dash only (seg=7'b0111111, g lit).
- Blink:
  - A frame counter counts wraps 0..BLINK_DIV-1.
  - On its terminal wrap, the blink phase toggles.
  - When blink_en=1 and phase=hidden, digits in the selected field drive an bit high (blank); seg and dp still update.
  - When blink_en=0, the phase keeps running but is ignored.
  - Deasserting blink_en makes the field visible from the next tick onward.
- Colon: dp=0 on idx 2 and idx 4 when colon_en=1; otherwise dp=1. Colon is not affected by blink.
- Exactly one an bit is low at any time, except after reset or when blanked.
- Reset mid-frame returns the block to the reset state on the next edge. The first digit appears after SCAN_DIV cycles.
- Simultaneous shadow capture and blink toggle on the same edge is legal; both take effect for digit 0.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_0..SEG_9 and SEG_DASH constants
  - field encodings FLD_SD, FLD_MN, FLD_HR, FLD_ALL
  - NUM_DIGITS=6
- One combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out), instantiated once on the mux-selected nibble.

Test Plan:
- Scan order and timing. Stimulus: SCAN_DIV=4, tm=24'h123456, no blink or colon, 30 cycles. Required: an steps 111110→111101→…→011111 every 4 cycles; seg shows 6,5,4,3,2,1 in that order; frame pulses every 24 cycles.
- Snapshot atomicity. Stimulus: change tm to 24'h235959 while idx=3. Required: remaining digits still show the old value; the new value appears starting at the next idx=0.
- Invalid BCD. Stimulus: tm=24'h1A0000. Required: digit 4 shows seg=7'b0111111; the other digits decode normally.
- Blink mn. Stimulus: SCAN_DIV=4, BLINK_DIV=2, blink_en=1, blink_sel=01. Required: an[3:2] stay high during alternate 2-frame windows while the other digits scan normally. With blink_sel=11, all an bits stay high in the hidden phase.
- Colon. Stimulus: colon_en=1. Required: dp=0 only while idx is 2 or 4. With colon_en=0, dp=1 always.
- Reset mid-scan. Stimulus: assert rst for 1 cycle at idx=4. Required: next cycle an=111111, seg=7'h7F; idx 0 is driven again after SCAN_DIV cycles.
